// File: rtl/instr_issue_queue.sv
// In-order issue queue that decodes R-type words into register-bank and ALU controls.
// Define ILLEGAL_COUNT_EN to build the saturating illegal-word counter.
module instr_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_instr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [4:0]  out_read_reg1,
  output logic [4:0]  out_read_reg2,
  output logic [4:0]  out_write_reg,
  output logic [2:0]  out_sel,
  output logic        out_reg_write,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        illegal,
  output logic [7:0]  illegal_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [2:0] sel;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  entry_t        dec_entry;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          run;
  logic          legal;
  logic [2:0]    dec_sel;
  logic          op_ok;
  logic [5:0]    funct;
  logic          accept;
  logic          push;
  logic          pop;
  logic          unused_shamt;

  assign unused_shamt = ^in_instr[10:6];

  assign op_ok = (in_instr[31:26] == 6'd0);
  assign funct = in_instr[5:0];

  always_comb begin
    legal   = 1'b1;
    dec_sel = 3'd0;
    unique case (1'b1)
      op_ok && (funct == 6'h20): dec_sel = 3'd0;
      op_ok && (funct == 6'h22): dec_sel = 3'd1;
      op_ok && (funct == 6'h2A): dec_sel = 3'd2;
      op_ok && (funct == 6'h24): dec_sel = 3'd3;
      op_ok && (funct == 6'h25): dec_sel = 3'd4;
      op_ok && (funct == 6'h26): dec_sel = 3'd5;
      default:                   legal   = 1'b0;
    endcase
  end

  assign dec_entry.rs  = in_instr[25:21];
  assign dec_entry.rt  = in_instr[20:16];
  assign dec_entry.rd  = in_instr[15:11];
  assign dec_entry.sel = dec_sel;

  // run holds in_ready low while reset is active and until the first edge after it
  assign in_ready  = run && (count < FULL);
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      run     <= 1'b0;
      illegal <= 1'b0;
    end else begin
      run     <= 1'b1;
      illegal <= accept && !legal;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= dec_entry;
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    out_read_reg1 = '0;
    out_read_reg2 = '0;
    out_write_reg = '0;
    out_sel       = '0;
    out_reg_write = 1'b0;
    if (out_valid) begin
      out_read_reg1 = head.rs;
      out_read_reg2 = head.rt;
      out_write_reg = head.rd;
      out_sel       = head.sel;
      out_reg_write = (head.rd != 5'd0);
    end
  end

`ifdef ILLEGAL_COUNT_EN
  logic [7:0] ill_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_cnt <= '0;
    end else if (accept && !legal && (ill_cnt != 8'hFF)) begin
      ill_cnt <= ill_cnt + 8'd1;
    end
  end

  assign illegal_count = ill_cnt;
`else
  assign illegal_count = '0;
`endif

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed plus random checks of instr_issue_queue against a queue-based model.
// Honours ILLEGAL_COUNT_EN for the expected illegal_count.
module tb_instr_issue_queue;

  localparam int DEPTH = 4;
  localparam logic [5:0] FTAB [6] = '{6'h20, 6'h22, 6'h2A, 6'h24, 6'h25, 6'h26};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  out_read_reg1;
  logic [4:0]  out_read_reg2;
  logic [4:0]  out_write_reg;
  logic [2:0]  out_sel;
  logic        out_reg_write;
  logic        out_valid;
  logic        out_ready;
  logic        illegal;
  logic [7:0]  illegal_count;

  always #5 clk = ~clk;

  instr_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_instr(in_instr),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_read_reg1(out_read_reg1),
    .out_read_reg2(out_read_reg2),
    .out_write_reg(out_write_reg),
    .out_sel(out_sel),
    .out_reg_write(out_reg_write),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .illegal(illegal),
    .illegal_count(illegal_count)
  );

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [2:0] sel;
  } ent_t;

  ent_t q[$];
  ent_t seen[$];
  logic ill_m;
  int   cnt_m;
  int   checks = 0;
  int   errors = 0;

`ifdef ILLEGAL_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [5:0] fn);
    return {op, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic int dec(input logic [31:0] w);
    if (w[31:26] != 6'd0) return -1;
    for (int i = 0; i < 6; i++) begin
      if (FTAB[i] == w[5:0]) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    ent_t h;
    logic v;
    v = (q.size() > 0);
    h = v ? q[0] : '0;
    chk("out_valid", out_valid, v);
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("read_reg1", out_read_reg1, h.rs);
    chk("read_reg2", out_read_reg2, h.rt);
    chk("write_reg", out_write_reg, h.rd);
    chk("sel", out_sel, h.sel);
    chk("reg_write", out_reg_write, v && (h.rd != 5'd0));
    chk("illegal", illegal, ill_m);
    chk("illegal_count", illegal_count, cnt_m);
  endtask

  // Starts and ends 1 time unit after a rising edge.
  task automatic cycle(input logic [31:0] w, input logic v, input logic r);
    int  s;
    bit  acc;
    bit  pop;
    in_instr  = w;
    in_valid  = v;
    out_ready = r;
    #1;
    check_state();
    acc = v && (q.size() < DEPTH);
    pop = r && (q.size() > 0);
    if (r && out_valid) begin
      seen.push_back(ent_t'{rs: out_read_reg1, rt: out_read_reg2,
                            rd: out_write_reg, sel: out_sel});
    end
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    s = dec(w);
    ill_m = acc && (s < 0);
    if (acc && s >= 0) begin
      q.push_back(ent_t'{rs: w[25:21], rt: w[20:16], rd: w[15:11], sel: s[2:0]});
    end
    if (CNT_EN && ill_m && cnt_m < 255) cnt_m++;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) cycle(32'd0, 1'b0, 1'b1);
  endtask

  logic [4:0]  rds  [6] = '{5'd1, 5'd5, 5'd6, 5'd9, 5'd3, 5'd22};
  logic [5:0]  fns  [6] = '{6'h22, 6'h2A, 6'h24, 6'h25, 6'h26, 6'h24};
  logic [2:0]  sels [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd3};

  initial begin
    rst_n     = 1'b0;
    in_instr  = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ill_m     = 1'b0;
    cnt_m     = 0;
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_illegal_count", illegal_count, 8'd0);
    chk("rst_write_reg", out_write_reg, 5'd0);
    chk("rst_reg_write", out_reg_write, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);

    cycle(32'h01AA4020, 1'b1, 1'b0);
    in_valid = 1'b0;
    #1;
    chk("single_valid", out_valid, 1'b1);
    chk("single_reg1", out_read_reg1, 5'd13);
    chk("single_reg2", out_read_reg2, 5'd10);
    chk("single_wr", out_write_reg, 5'd8);
    chk("single_sel", out_sel, 3'd0);
    chk("single_we", out_reg_write, 1'b1);
    drain();

    for (int i = 0; i < 5; i++) begin
      cycle(mk(6'd0, 5'(i + 1), 5'(i + 2), 5'(i + 10), 6'h20), 1'b1, 1'b0);
      if (i == 3) chk("full_in_ready", in_ready, 1'b0);
    end
    chk("full_head_wr", out_write_reg, 5'd10);
    chk("full_head_reg1", out_read_reg1, 5'd1);
    drain();

    seen.delete();
    for (int i = 0; i < 6; i++) cycle(mk(6'd0, 5'd1, 5'd2, rds[i], fns[i]), 1'b1, 1'(i % 2));
    drain();
    chk("order_count", seen.size(), 6);
    for (int i = 0; i < 6 && i < seen.size(); i++) begin
      chk("order_sel", seen[i].sel, sels[i]);
      chk("order_wr", seen[i].rd, rds[i]);
    end

    cycle(mk(6'd0, 5'd1, 5'd2, 5'd3, 6'h27), 1'b1, 1'b0);
    chk("ill_pulse1", illegal, 1'b1);
    cycle(mk(6'h23, 5'd1, 5'd2, 5'd3, 6'h20), 1'b1, 1'b0);
    chk("ill_pulse2", illegal, 1'b1);
    cycle(32'd0, 1'b0, 1'b0);
    chk("ill_pulse_end", illegal, 1'b0);
    chk("ill_queue_empty", out_valid, 1'b0);
    chk("ill_count2", illegal_count, CNT_EN ? 8'd2 : 8'd0);

    cycle(mk(6'd0, 5'd4, 5'd5, 5'd0, 6'h20), 1'b1, 1'b0);
    chk("rd0_valid", out_valid, 1'b1);
    chk("rd0_we", out_reg_write, 1'b0);
    drain();

    for (int i = 0; i < 300; i++) cycle(mk(6'h3F, 5'd1, 5'd1, 5'd1, 6'h20), 1'b1, 1'b1);
    cycle(32'd0, 1'b0, 1'b0);
    chk("ill_saturate", illegal_count, CNT_EN ? 8'd255 : 8'd0);

    for (int i = 0; i < 3; i++) cycle(mk(6'd0, 5'd2, 5'd3, 5'(i + 4), 6'h22), 1'b1, 1'b0);
    chk("pre_rst_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_wr", out_write_reg, 5'd0);
    chk("mid_rst_count", illegal_count, 8'd0);
    q.delete();
    ill_m = 1'b0;
    cnt_m = 0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(mk(6'd0, 5'd7, 5'd8, 5'd9, 6'h25), 1'b1, 1'b0);
    chk("after_rst_valid", out_valid, 1'b1);
    chk("after_rst_wr", out_write_reg, 5'd9);
    chk("after_rst_sel", out_sel, 3'd4);
    drain();

    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      if ($urandom_range(0, 3) != 0) begin
        w = mk(6'd0, 5'($urandom), 5'($urandom), 5'($urandom), FTAB[$urandom_range(0, 5)]);
      end else begin
        w = $urandom;
      end
      cycle(w, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end
    drain();
    check_state();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_issue_queue.md
INSTR_ISSUE_QUEUE -- requirements
Module: instr_issue_queue

Interface
REQ-001 The interface SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of queue entries (power of two, 2..16).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_instr  input  32  R-type instruction word: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0].
REQ-006 in_valid  input  1  in_instr is valid this cycle.
REQ-007 in_ready  output  1  queue can accept an instruction this cycle.
REQ-008 out_read_reg1  output  5  rs of the head entry, to the register bank's first read port.
REQ-009 out_read_reg2  output  5  rt of the head entry, to the register bank's second read port.
REQ-010 out_write_reg  output  5  rd of the head entry, the register bank's write address.
REQ-011 out_sel  output  3  ALU selector of the head entry.
REQ-012 out_reg_write  output  1  write enable: out_valid and (rd != 0).
REQ-013 out_valid  output  1  head entry is presented.
REQ-014 out_ready  input  1  datapath consumes the head entry this cycle.
REQ-015 illegal  output  1  one-cycle pulse when an accepted word fails decode.
REQ-016 illegal_count  output  8  saturating count of illegal words.

Function
REQ-017 A transfer SHALL occur on an input or output port only on a rising edge where the port's valid and ready are both 1.
REQ-018 in_ready SHALL equal 1 exactly when the occupancy is less than DEPTH; the queue SHALL NOT accept a push into a full queue, even when a pop occurs in the same cycle.
REQ-019 Decode SHALL occur at acceptance: funct 0x20->0 (add), 0x22->1 (sub), 0x2A->2 (slt), 0x24->3 (and), 0x25->4 (or), 0x26->5 (xor).
REQ-020 A word with opcode != 0 or an unlisted funct SHALL be accepted (consumed) but not enqueued, and illegal SHALL be 1 for the single cycle after the accepting edge.
REQ-021 Latency: a legal word accepted at edge N into an empty queue SHALL be presented with out_valid=1 after edge N (one cycle); there is no same-cycle bypass.
REQ-022 out_valid SHALL equal 1 exactly when the occupancy is greater than 0; outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 Entries SHALL leave the queue in acceptance order (FIFO); the read and write pointers SHALL wrap modulo DEPTH.
REQ-024 A simultaneous legal push and pop with 0 < occupancy < DEPTH SHALL leave the occupancy unchanged.
REQ-025 A simultaneous illegal push and pop SHALL decrement the occupancy by one.
REQ-026 When out_valid=0, out_read_reg1, out_read_reg2, out_write_reg, out_sel and out_reg_write SHALL all be 0.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately clear the pointers and the occupancy, and force out_valid=0, in_ready=0, illegal=0 and illegal_count=0, with all data outputs at 0.
REQ-028 in_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-029 Reset mid-operation SHALL discard all queued entries; no partial transfer SHALL survive.

Configuration
REQ-030 With macro ILLEGAL_COUNT_EN defined, illegal_count SHALL increment on each illegal pulse and saturate at 255.
REQ-031 Without ILLEGAL_COUNT_EN, illegal_count SHALL be tied to 0 and no counter logic SHALL exist; illegal SHALL still pulse.

Verification
REQ-032 Single issue: push 0x01AA4020 (add rs=13, rt=10, rd=8) into the empty queue with out_ready=0 -> the next cycle shows out_valid=1, reg1=13, reg2=10, wr=8, sel=0, reg_write=1.
REQ-033 Fill/backpressure: hold out_ready=0 and push 5 legal words with DEPTH=4 -> in_ready=0 after the 4th acceptance, the 5th word is held, and outputs stay on entry 0.
REQ-034 Ordering/wrap: push sub, slt, and, or, xor, and (rd=1,5,6,9,3,22) with out_ready toggled -> sel sequence 1,2,3,4,5,3 and wr sequence 1,5,6,9,3,22 in order.
REQ-035 Illegal: push funct 0x27 and opcode 0x23 words -> two illegal pulses, queue unchanged, and illegal_count=2 with ILLEGAL_COUNT_EN (0 without); after 300 illegal words the count reads 255.
REQ-036 rd=0: push add with rd=0 -> out_valid=1 and out_reg_write=0.
REQ-037 Reset mid-operation: with 3 entries queued, pulse rst_n low asynchronously between edges -> out_valid=0 immediately, and after release the first push reappears after one cycle.
